tank_render: RTL and testbench

TANK_RENDER -- requirements
Module: tank_render

---
 rtl/tank_render.sv | 123 ++++++++++++
 tb/tb_tank_render.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tank_render.sv
// Tank sprite renderer: a 32x32 body with a direction-dependent barrel, drawn from active
// registers that only change at frame end. Updates are staged in shadow registers.
module tank_render #(
  parameter logic [10:0] H_DISP       = 11'd640,
  parameter logic [10:0] V_DISP       = 11'd480,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BODY_COLOR   = 12'h0F0,
  parameter logic [11:0] BARREL_COLOR = 12'hFF0,
  parameter logic [10:0] INIT_X       = 11'd304,
  parameter logic [10:0] INIT_Y       = 11'd224
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VGA_request,
  input  logic [10:0] VGA_xpos,
  input  logic [10:0] VGA_ypos,
  output logic [11:0] VGA_data,
  input  logic        upd_valid,
  input  logic [10:0] upd_x,
  input  logic [10:0] upd_y,
  input  logic [1:0]  upd_dir,
  output logic        upd_ready,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);

  typedef enum logic {StIdle, StPending} state_e;

  state_e      state_q, state_d;
  logic [10:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [10:0] shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic [1:0]  act_dir_q, act_dir_d, shd_dir_q, shd_dir_d;
  logic        frame_tick_q, frame_tick_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [11:0] vga_data_q, vga_data_d;

  logic        fe, hs;
  logic [10:0] dx, dy;
  logic        in_body, in_barrel;
  logic [11:0] pix;

  assign upd_ready  = (state_q == StIdle) && !rst;
  assign fe         = VGA_request && (VGA_xpos == H_DISP - 11'd1) && (VGA_ypos == V_DISP - 11'd1);
  assign hs         = upd_valid && upd_ready;
  assign VGA_data   = vga_data_q;
  assign frame_tick = frame_tick_q;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d      = state_q;
    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    act_dir_d    = act_dir_q;
    shd_x_d      = shd_x_q;
    shd_y_d      = shd_y_q;
    shd_dir_d    = shd_dir_q;
    frame_tick_d = fe;
    frame_cnt_d  = frame_cnt_q + {15'd0, fe};
    unique case (state_q)
      StIdle: begin
        // A handshake on the frame-end cycle waits for the next frame end.
        if (hs) begin
          shd_x_d   = upd_x;
          shd_y_d   = upd_y;
          shd_dir_d = upd_dir;
          state_d   = StPending;
        end
      end
      StPending: begin
        if (fe) begin
          act_x_d   = shd_x_q;
          act_y_d   = shd_y_q;
          act_dir_d = shd_dir_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dx      = VGA_xpos - act_x_q;
    dy      = VGA_ypos - act_y_q;
    in_body = (VGA_xpos >= act_x_q) && (VGA_ypos >= act_y_q) && (dx < 11'd32) && (dy < 11'd32);
    unique case (act_dir_q)
      2'd0:    in_barrel = (dx >= 11'd14) && (dx <= 11'd17) && (dy <= 11'd15);
      2'd1:    in_barrel = (dx >= 11'd14) && (dx <= 11'd17) && (dy >= 11'd16);
      2'd2:    in_barrel = (dy >= 11'd14) && (dy <= 11'd17) && (dx <= 11'd15);
      default: in_barrel = (dy >= 11'd14) && (dy <= 11'd17) && (dx >= 11'd16);
    endcase
    if (in_body && in_barrel) pix = BARREL_COLOR;
    else if (in_body)         pix = BODY_COLOR;
    else                      pix = BG_COLOR;
    vga_data_d = VGA_request ? pix : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      act_x_q      <= INIT_X;
      act_y_q      <= INIT_Y;
      act_dir_q    <= 2'd0;
      shd_x_q      <= INIT_X;
      shd_y_q      <= INIT_Y;
      shd_dir_q    <= 2'd0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= 16'h0000;
      vga_data_q   <= 12'h000;
    end else begin
      state_q      <= state_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      act_dir_q    <= act_dir_d;
      shd_x_q      <= shd_x_d;
      shd_y_q      <= shd_y_d;
      shd_dir_q    <= shd_dir_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
      vga_data_q   <= vga_data_d;
    end
  end

endmodule

// File: tb/tb_tank_render.sv
// Directed bench for tank_render: pixel colours, frame-end update staging, reset and counter wrap.
module tb_tank_render;

  logic        clk = 1'b0;
  logic        rst;
  logic        VGA_request;
  logic [10:0] VGA_xpos, VGA_ypos;
  logic [11:0] VGA_data;
  logic        upd_valid;
  logic [10:0] upd_x, upd_y;
  logic [1:0]  upd_dir;
  logic        upd_ready;
  logic        frame_tick;
  logic [15:0] frame_cnt;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tank_render dut (
    .clk         (clk),
    .rst         (rst),
    .VGA_request (VGA_request),
    .VGA_xpos    (VGA_xpos),
    .VGA_ypos    (VGA_ypos),
    .VGA_data    (VGA_data),
    .upd_valid   (upd_valid),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_dir     (upd_dir),
    .upd_ready   (upd_ready),
    .frame_tick  (frame_tick),
    .frame_cnt   (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    VGA_request = 1'b0;
    upd_valid   = 1'b0;
    step();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    VGA_request = 1'b1;
    VGA_xpos    = 11'(x);
    VGA_ypos    = 11'(y);
    step();
    VGA_request = 1'b0;
    check(tag, {20'd0, VGA_data}, {20'd0, exp});
  endtask

  // One frame-end request, optionally with an update offered on the same cycle.
  task automatic frame_end(input logic with_upd, input int x, input int y, input logic [1:0] d);
    VGA_request = 1'b1;
    VGA_xpos    = 11'd639;
    VGA_ypos    = 11'd479;
    upd_valid   = with_upd;
    upd_x       = 11'(x);
    upd_y       = 11'(y);
    upd_dir     = d;
    step();
    VGA_request = 1'b0;
    upd_valid   = 1'b0;
  endtask

  task automatic offer(input int x, input int y, input logic [1:0] d);
    upd_valid = 1'b1;
    upd_x     = 11'(x);
    upd_y     = 11'(y);
    upd_dir   = d;
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; VGA_request = 1'b0; VGA_xpos = '0; VGA_ypos = '0;
    upd_valid = 1'b0; upd_x = '0; upd_y = '0; upd_dir = '0;
    step(); step();
    check("rst_data", {20'd0, VGA_data}, 32'h000);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst_ready", {31'd0, upd_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, upd_ready}, 32'd1);

    pix("barrel_up", 320, 224, 12'hFF0);
    pix("body", 304, 250, 12'h0F0);
    pix("right_of_body", 336, 224, 12'h000);
    pix("left_of_body", 303, 224, 12'h000);
    pix("corner", 335, 255, 12'h0F0);
    idle_cyc();
    check("no_request", {20'd0, VGA_data}, 32'h000);

    // Mid-frame update: staged until frame end.
    offer(100, 50, 2'd3);
    check("ready_pending", {31'd0, upd_ready}, 32'd0);
    pix("old_image", 320, 224, 12'hFF0);
    frame_end(1'b0, 0, 0, 2'd0);
    check("tick1", {31'd0, frame_tick}, 32'd1);
    check("cnt1", {16'd0, frame_cnt}, 32'd1);
    check("ready_after_fe", {31'd0, upd_ready}, 32'd1);
    idle_cyc();
    check("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
    pix("right_barrel", 120, 66, 12'hFF0);
    pix("right_barrel_edge", 116, 66, 12'hFF0);
    pix("right_body_left", 115, 66, 12'h0F0);
    pix("right_top_body", 116, 50, 12'h0F0);
    pix("old_pos_gone", 320, 224, 12'h000);

    // Handshake on the frame-end cycle is applied one frame later.
    frame_end(1'b1, 200, 100, 2'd1);
    check("cnt2", {16'd0, frame_cnt}, 32'd2);
    check("ready_coincide", {31'd0, upd_ready}, 32'd0);
    pix("still_old", 120, 66, 12'hFF0);
    pix("new_not_yet", 214, 131, 12'h000);
    frame_end(1'b0, 0, 0, 2'd0);
    check("cnt3", {16'd0, frame_cnt}, 32'd3);
    pix("down_barrel", 214, 131, 12'hFF0);
    pix("down_body", 214, 115, 12'h0F0);

    // Origin near the bottom-right corner clips without wrapping.
    offer(630, 470, 2'd0);
    frame_end(1'b0, 0, 0, 2'd0);
    pix("clip_corner", 639, 479, 12'h0F0);
    pix("clip_origin", 630, 470, 12'h0F0);
    pix("no_wrap_xy", 5, 5, 12'h000);
    pix("no_wrap_x", 0, 479, 12'h000);
    pix("no_wrap_y", 639, 0, 12'h000);

    // Reset while pending discards the shadow.
    offer(50, 50, 2'd2);
    check("ready_before_rst", {31'd0, upd_ready}, 32'd0);
    rst = 1'b1;
    step();
    check("rst2_cnt", {16'd0, frame_cnt}, 32'd0);
    check("rst2_data", {20'd0, VGA_data}, 32'h000);
    rst = 1'b0;
    #1;
    check("ready_rst2", {31'd0, upd_ready}, 32'd1);
    pix("init_barrel", 320, 224, 12'hFF0);
    frame_end(1'b0, 0, 0, 2'd0);
    check("cnt_after_rst", {16'd0, frame_cnt}, 32'd1);
    pix("discarded_left", 60, 66, 12'h000);
    pix("init_still", 320, 224, 12'hFF0);

    // Counter wrap: 65535 more frame ends from 1 brings it to 0.
    VGA_request = 1'b1;
    VGA_xpos    = 11'd639;
    VGA_ypos    = 11'd479;
    for (int i = 0; i < 65534; i++) step();
    check("cnt_ffff", {16'd0, frame_cnt}, 32'hFFFF);
    step();
    VGA_request = 1'b0;
    check("cnt_wrap", {16'd0, frame_cnt}, 32'h0000);
    check("tick_wrap", {31'd0, frame_tick}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
